// File: rtl/alu_exec_unit.sv
// EX-stage ALU: ALUOp/funct decode, registered result with valid/ready handshake.
// Define ALU_BARREL_SHIFT_EN for single-cycle shifts; otherwise shifts iterate 1 bit/cycle.
module alu_exec_unit #(
  parameter int DATA_W = 32,
  parameter int SH_W   = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        ALUOp,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [SH_W-1:0]   shamt,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              ovf,
  output logic              ill_op,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT, OP_SLL, OP_SRL, OP_ILL
  } op_e;

  op_e               op;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic [DATA_W-1:0] alu_res;
  logic              alu_ovf;
  logic              alu_ill;
  logic              is_shift;
  logic              accept;

  assign sum    = a + b;
  assign diff   = a - b;
  assign accept = in_valid && in_ready;

  always_comb begin
    op = OP_ILL;
    unique case (ALUOp)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b11: op = OP_SLT;
      default: begin
        case (funct)
          6'b100000: op = OP_ADD;
          6'b100010: op = OP_SUB;
          6'b100100: op = OP_AND;
          6'b100101: op = OP_OR;
          6'b100111: op = OP_NOR;
          6'b101010: op = OP_SLT;
          6'b000000: op = OP_SLL;
          6'b000010: op = OP_SRL;
          default:   op = OP_ILL;
        endcase
      end
    endcase
  end

  always_comb begin
    alu_res  = '0;
    alu_ovf  = 1'b0;
    alu_ill  = 1'b0;
    is_shift = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_NOR: alu_res = ~(a | b);
      OP_SLT: alu_res = DATA_W'($signed(a) < $signed(b));
`ifdef ALU_BARREL_SHIFT_EN
      OP_SLL: begin is_shift = 1'b1; alu_res = b << shamt; end
      OP_SRL: begin is_shift = 1'b1; alu_res = b >> shamt; end
`else
      // Only the shamt==0 case completes here; n>0 goes through the shift FSM.
      OP_SLL: begin is_shift = 1'b1; alu_res = b; end
      OP_SRL: begin is_shift = 1'b1; alu_res = b; end
`endif
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef ALU_BARREL_SHIFT_EN

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      ill_op    <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept) begin
      result    <= alu_res;
      zero      <= (alu_res == '0);
      ovf       <= alu_ovf;
      ill_op    <= alu_ill;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`else

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e            state;
  state_e            state_next;
  logic [DATA_W-1:0] sreg;
  logic [DATA_W-1:0] sreg_next;
  logic [SH_W-1:0]   count;
  logic              shift_left;
  logic              start_shift;
  logic              last_step;

  assign start_shift = accept && is_shift && (shamt != '0);
  assign last_step   = (state == SHIFT) && (count == SH_W'(1));
  assign sreg_next   = shift_left ? {sreg[DATA_W-2:0], 1'b0} : {1'b0, sreg[DATA_W-1:1]};

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !out_valid || out_ready;
        if (start_shift) state_next = SHIFT;
      end
      SHIFT: begin
        if (count == SH_W'(1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      sreg       <= '0;
      shift_left <= 1'b0;
      result     <= '0;
      zero       <= 1'b0;
      ovf        <= 1'b0;
      ill_op     <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      state <= state_next;
      if (start_shift) begin
        sreg       <= b;
        count      <= shamt;
        shift_left <= (op == OP_SLL);
        out_valid  <= 1'b0;
      end else if (accept) begin
        result    <= alu_res;
        zero      <= (alu_res == '0);
        ovf       <= alu_ovf;
        ill_op    <= alu_ill;
        out_valid <= 1'b1;
      end else if (state == SHIFT) begin
        sreg  <= sreg_next;
        count <= count - SH_W'(1);
        if (last_step) begin
          result    <= sreg_next;
          zero      <= (sreg_next == '0);
          ovf       <= 1'b0;
          ill_op    <= 1'b0;
          out_valid <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`endif

endmodule
